// File: rtl/serial_word_deserializer.sv
// Serial-to-parallel word assembler framed by a start pulse, with a one-cycle valid strobe.
// Optional trailing even-parity bit is enabled by defining PARITY_CHECK_EN.
module serial_word_deserializer #(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          d_in,
    input  logic                          shift_en,
    input  logic                          start,
    output logic [WIDTH-1:0]              word_out,
    output logic                          word_valid,
    output logic                          busy,
    output logic [$clog2(WIDTH+2)-1:0]    bit_count,
    output logic                          parity_err
);

    localparam int CW = $clog2(WIDTH+2);
`ifdef PARITY_CHECK_EN
    localparam int NBITS = WIDTH + 1;
`else
    localparam int NBITS = WIDTH;
`endif
    localparam logic [CW-1:0] LAST_IDX = CW'(NBITS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state_q;
    logic [WIDTH-1:0]  shreg_q;
    logic [WIDTH-1:0]  shreg_d;
    logic [WIDTH-1:0]  word_q;
    logic              valid_q;
    logic              busy_q;
    logic [CW-1:0]     cnt_q;

    function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] sr, input logic b);
        if (MSB_FIRST != 0)
            return {sr[WIDTH-2:0], b};
        else
            return {b, sr[WIDTH-1:1]};
    endfunction

    always_comb begin
        shreg_d = shift_in(shreg_q, d_in);
    end

`ifdef PARITY_CHECK_EN
    logic perr_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            word_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
`ifdef PARITY_CHECK_EN
            perr_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    valid_q <= 1'b0;
                    if (start) begin
                        state_q <= SHIFT;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                    end
                end
                SHIFT: begin
                    if (shift_en) begin
                        cnt_q <= cnt_q + 1'b1;
`ifdef PARITY_CHECK_EN
                        // The parity bit is checked against the held data, never shifted in.
                        if (cnt_q == LAST_IDX) begin
                            word_q <= shreg_q;
                            perr_q <= (^shreg_q) ^ d_in;
                        end else begin
                            shreg_q <= shreg_d;
                        end
`else
                        shreg_q <= shreg_d;
                        if (cnt_q == LAST_IDX)
                            word_q <= shreg_d;
`endif
                        if (cnt_q == LAST_IDX) begin
                            valid_q <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= DONE;
                        end
                    end
                end
                DONE: begin
                    valid_q <= 1'b0;
                    cnt_q   <= '0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign word_out   = word_q;
    assign word_valid = valid_q;
    assign busy       = busy_q;
    assign bit_count  = cnt_q;
`ifdef PARITY_CHECK_EN
    assign parity_err = perr_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_serial_word_deserializer.sv
// Scoreboard bench: MSB-first and LSB-first instances share one serial stream; a monitor
// per instance pops expected words whenever word_valid is seen.
module tb_serial_word_deserializer;

    localparam int WIDTH = 8;
    localparam int CW    = $clog2(WIDTH+2);
`ifdef PARITY_CHECK_EN
    localparam int N = WIDTH + 1;
    localparam bit PAR = 1'b1;
`else
    localparam int N = WIDTH;
    localparam bit PAR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst, d_in, shift_en, start;

    logic [WIDTH-1:0] wo1, wo0;
    logic             wv1, wv0, b1, b0, pe1, pe0;
    logic [CW-1:0]    bc1, bc0;

    typedef struct {
        logic [WIDTH-1:0] w;
        logic             p;
    } exp_t;

    exp_t q1[$];
    exp_t q0[$];

    int checks = 0;
    int errors = 0;
    logic [WIDTH-1:0] last1 = '0;
    logic [WIDTH-1:0] last0 = '0;
    logic pv1 = 1'b0;
    logic pv0 = 1'b0;

    always #5 clk = ~clk;

    serial_word_deserializer #(.WIDTH(WIDTH), .MSB_FIRST(1)) dut_msb (
        .clk(clk), .rst(rst), .d_in(d_in), .shift_en(shift_en), .start(start),
        .word_out(wo1), .word_valid(wv1), .busy(b1), .bit_count(bc1), .parity_err(pe1)
    );

    serial_word_deserializer #(.WIDTH(WIDTH), .MSB_FIRST(0)) dut_lsb (
        .clk(clk), .rst(rst), .d_in(d_in), .shift_en(shift_en), .start(start),
        .word_out(wo0), .word_valid(wv0), .busy(b0), .bit_count(bc0), .parity_err(pe0)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitors sample on the falling edge, well away from the active edge.
    always @(negedge clk) begin
        exp_t e;
        if (pv1) chk("valid_one_cycle_msb", 32'(wv1), 0);
        if (wv1) begin
            chk("expect_pending_msb", 32'(q1.size() != 0), 1);
            if (q1.size() != 0) begin
                e = q1.pop_front();
                chk("word_msb", 32'(wo1), 32'(e.w));
                chk("perr_msb", 32'(pe1), 32'(e.p));
                chk("busy_at_valid_msb", 32'(b1), 0);
            end
        end
        pv1 <= wv1;
    end

    always @(negedge clk) begin
        exp_t e;
        if (pv0) chk("valid_one_cycle_lsb", 32'(wv0), 0);
        if (wv0) begin
            chk("expect_pending_lsb", 32'(q0.size() != 0), 1);
            if (q0.size() != 0) begin
                e = q0.pop_front();
                chk("word_lsb", 32'(wo0), 32'(e.w));
                chk("perr_lsb", 32'(pe0), 32'(e.p));
            end
        end
        pv0 <= wv0;
    end

    task automatic chk_reset_state();
        chk("rst_word_msb", 32'(wo1), 0);
        chk("rst_word_lsb", 32'(wo0), 0);
        chk("rst_valid", 32'({wv1, wv0}), 0);
        chk("rst_busy", 32'({b1, b0}), 0);
        chk("rst_count_msb", 32'(bc1), 0);
        chk("rst_count_lsb", 32'(bc0), 0);
        chk("rst_perr", 32'({pe1, pe0}), 0);
    endtask

    // seq[WIDTH-1] is the first bit on the wire. gap<0 means a fixed gap of -gap cycles.
    task automatic send_seq(input logic [WIDTH-1:0] seq, input bit flip, input int gap, input int abort_at);
        logic bits[N];
        logic [WIDTH-1:0] exp_msb, exp_lsb;
        exp_t e1, e0;
        int g;
        for (int i = 0; i < WIDTH; i++) bits[i] = seq[WIDTH-1-i];
        if (PAR) bits[N-1] = (^seq) ^ flip;
        for (int i = 0; i < WIDTH; i++) begin
            exp_msb[WIDTH-1-i] = bits[i];
            exp_lsb[i]         = bits[i];
        end

        start = 1'b1; shift_en = 1'($urandom % 2); d_in = 1'($urandom % 2);
        tick();
        start = 1'b0; shift_en = 1'b0;
        chk("busy_after_start", 32'({b1, b0}), 32'h3);
        chk("count_after_start", 32'({bc1, bc0}), 0);

        for (int i = 0; i < N; i++) begin
            g = (gap < 0) ? -gap : int'($urandom_range(0, gap));
            for (int k = 0; k < g; k++) begin
                shift_en = 1'b0; d_in = 1'($urandom % 2); start = 1'($urandom % 2);
                tick();
                chk("count_in_gap", 32'(bc1), 32'(i));
            end
            if (abort_at == i) begin
                rst = 1'b1; start = 1'b0; shift_en = 1'b0;
                tick();
                rst = 1'b0;
                chk_reset_state();
                last1 = '0; last0 = '0;
                return;
            end
            if (i == N-1) begin
                e1.w = exp_msb; e1.p = PAR & flip;
                e0.w = exp_lsb; e0.p = PAR & flip;
                q1.push_back(e1);
                q0.push_back(e0);
            end
            shift_en = 1'b1; d_in = bits[i]; start = 1'($urandom % 2);
            tick();
            shift_en = 1'b0; start = 1'b0;
            if (i < N-1) begin
                chk("count_msb", 32'(bc1), 32'(i+1));
                chk("count_lsb", 32'(bc0), 32'(i+1));
                chk("word_hold_msb", 32'(wo1), 32'(last1));
                chk("word_hold_lsb", 32'(wo0), 32'(last0));
                chk("busy_mid", 32'(b1), 1);
            end
        end
        last1 = exp_msb; last0 = exp_lsb;

        // DONE cycle: start/shift_en must be ignored here.
        start = 1'($urandom % 2); shift_en = 1'($urandom % 2); d_in = 1'($urandom % 2);
        tick();
        start = 1'b0;
        chk("count_cleared", 32'({bc1, bc0}), 0);
        chk("busy_after_done", 32'({b1, b0}), 0);
        chk("valid_dropped", 32'({wv1, wv0}), 0);

        // Idle cycle with shift_en high must not sample.
        shift_en = 1'b1; d_in = 1'($urandom % 2);
        tick();
        shift_en = 1'b0;
        chk("idle_no_sample", 32'(bc1), 0);
        chk("idle_word_hold", 32'(wo1), 32'(last1));
    endtask

    initial begin
        rst = 1'b1; d_in = 1'b0; shift_en = 1'b0; start = 1'b0;
        repeat (2) tick();
        chk_reset_state();
        rst = 1'b0;
        tick();

        send_seq(8'b10100101, 1'b0, 0, -1);
        send_seq(8'b10100101, 1'b0, -3, -1);
        send_seq(8'b11000000, 1'b0, 0, -1);
        send_seq(8'h3C, 1'b0, 0, 4);
        send_seq(8'hC3, 1'b0, 1, -1);
        send_seq(8'hA5, 1'b0, 0, -1);
        send_seq(8'hA5, 1'b1, 0, -1);

        for (int t = 0; t < 40; t++) begin
            send_seq(WIDTH'($urandom), 1'($urandom % 2), 3,
                     ($urandom % 6 == 0) ? int'($urandom_range(0, N-1)) : -1);
        end

        repeat (3) tick();
        chk("scoreboard_drained_msb", 32'(q1.size()), 0);
        chk("scoreboard_drained_lsb", 32'(q0.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
